// File: rtl/bus_pkg.sv
// Shared types, default address map and helpers for the bus address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } dec_state_t;

  localparam int MAX_SLAVES = 15;

  localparam logic [15:0] DEF_BASE_0 = 16'h0000;
  localparam logic [15:0] DEF_BASE_1 = 16'h1000;
  localparam logic [15:0] DEF_BASE_2 = 16'h2000;

  localparam logic [7:0] DEF_SZLG_0 = 8'd11;
  localparam logic [7:0] DEF_SZLG_1 = 8'd12;
  localparam logic [7:0] DEF_SZLG_2 = 8'd12;

  localparam logic [47:0] DEF_SLAVE_BASE = {DEF_BASE_2, DEF_BASE_1, DEF_BASE_0};
  localparam logic [23:0] DEF_SLAVE_SZLG = {DEF_SZLG_2, DEF_SZLG_1, DEF_SZLG_0};

  // One-hot (bit i) to encoded index (i+1); zero maps to zero.
  function automatic logic [3:0] sel_encode(input logic [MAX_SLAVES-1:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
      if (onehot[i]) idx = 4'(i + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational window compare for every slave, reduced to a lowest-index-wins one-hot.
module bus_addr_match #(
  parameter int                          ADDR_W     = 16,
  parameter int                          N_SLAVES   = 3,
  parameter logic [ADDR_W*N_SLAVES-1:0]  SLAVE_BASE = bus_pkg::DEF_SLAVE_BASE,
  parameter logic [8*N_SLAVES-1:0]       SLAVE_SZLG = bus_pkg::DEF_SLAVE_SZLG
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_SLAVES-1:0] hit_onehot,
  output logic                hit_any
);

  logic [N_SLAVES-1:0] hit_raw;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_win
    localparam logic [7:0]        SZ   = SLAVE_SZLG[8*i +: 8];
    localparam logic [ADDR_W-1:0] BASE = SLAVE_BASE[ADDR_W*i +: ADDR_W];
    assign hit_raw[i] = ((addr >> SZ) == (BASE >> SZ));
  end

  // Two's-complement trick isolates the lowest set bit, so overlaps resolve to the lowest index.
  assign hit_onehot = hit_raw & (~hit_raw + N_SLAVES'(1));
  assign hit_any    = |hit_raw;

endmodule

// File: rtl/bus_addr_decoder_fsm.sv
// Transaction-aware address decoder: accepts one request, holds the slave select until
// the slave signals done or the timeout expires, and pulses dec_err on unmapped addresses.
module bus_addr_decoder_fsm
  import bus_pkg::*;
#(
  parameter int                          ADDR_W      = 16,
  parameter int                          N_SLAVES    = 3,
  parameter logic [ADDR_W*N_SLAVES-1:0]  SLAVE_BASE  = DEF_SLAVE_BASE,
  parameter logic [8*N_SLAVES-1:0]       SLAVE_SZLG  = DEF_SLAVE_SZLG,
  parameter int                          TIMEOUT_CYC = 255,
  parameter int                          SEL_W       = $clog2(N_SLAVES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  input  logic                txn_done,
  output logic [N_SLAVES-1:0] slave_sel,
  output logic [SEL_W-1:0]    selr,
  output logic                busy,
  output logic                dec_err,
  output logic                timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_ERR  = ERR;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]            state;
  logic [CNT_W-1:0]      tmo_cnt;
  logic [N_SLAVES-1:0]   hit_onehot;
  logic                  hit_any;
  logic [MAX_SLAVES-1:0] hit_pad;
  logic [SEL_W-1:0]      hit_enc;

  bus_addr_match #(
    .ADDR_W     (ADDR_W),
    .N_SLAVES   (N_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SZLG (SLAVE_SZLG)
  ) u_match (
    .addr       (req_addr),
    .hit_onehot (hit_onehot),
    .hit_any    (hit_any)
  );

  assign hit_pad   = MAX_SLAVES'(hit_onehot);
  assign hit_enc   = SEL_W'(sel_encode(hit_pad));
  // Handshake: a request transfers on a clock edge where req_valid && req_ready; ready only in IDLE.
  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      slave_sel <= '0;
      selr      <= '0;
      busy      <= 1'b0;
      dec_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      dec_err <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (hit_any) begin
              state     <= ST_BUSY;
              slave_sel <= hit_onehot;
              selr      <= hit_enc;
              busy      <= 1'b1;
              tmo_cnt   <= '0;
            end else begin
              state     <= ST_ERR;
              dec_err   <= 1'b1;
              slave_sel <= '0;
              selr      <= '0;
            end
          end
        end
        ST_BUSY: begin
          // txn_done takes precedence over an expiring timeout.
          if (txn_done || (tmo_cnt == TMO_LAST)) begin
            state     <= ST_IDLE;
            timeout   <= !txn_done;
            slave_sel <= '0;
            selr      <= '0;
            busy      <= 1'b0;
            tmo_cnt   <= '0;
          end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          slave_sel <= '0;
          selr      <= '0;
          busy      <= 1'b0;
          tmo_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_addr_decoder_fsm.sv
// Bench for bus_addr_decoder_fsm: per-cycle comparison against a transaction-level model
// plus directed scenarios with literal expectations.
module tb_bus_addr_decoder_fsm;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        txn_done;
  logic [2:0]  slave_sel;
  logic [1:0]  selr;
  logic        busy;
  logic        dec_err;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  bus_addr_decoder_fsm #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .txn_done  (txn_done),
    .slave_sel (slave_sel),
    .selr      (selr),
    .busy      (busy),
    .dec_err   (dec_err),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // Address map as plain numbers: window i covers base_i .. base_i + 2**szlg_i - 1.
  function automatic int decode(input logic [15:0] a);
    int bases [3];
    int szl [3];
    bases = '{'h0000, 'h1000, 'h2000};
    szl   = '{11, 12, 12};
    for (int i = 0; i < 3; i++) begin
      if ((int'(a) / (1 << szl[i])) == (bases[i] / (1 << szl[i]))) return i;
    end
    return -1;
  endfunction

  int m_sel = -1;  // slave currently owning the bus, -1 = none
  int m_age = 0;   // busy cycles elapsed in the current transaction
  bit m_err = 0;
  bit m_tmo = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sel = -1; m_age = 0; m_err = 0; m_tmo = 0;
      end else begin
        bit was_ready;
        bit n_err;
        bit n_tmo;
        was_ready = (m_sel < 0) && !m_err;
        n_err = 0;
        n_tmo = 0;
        if (was_ready && req_valid) begin
          int d;
          d = decode(req_addr);
          if (d >= 0) begin
            m_sel = d;
            m_age = 1;
          end else begin
            n_err = 1;
          end
        end else if (m_sel >= 0) begin
          if (txn_done) begin
            m_sel = -1;
          end else if (m_age == TMO) begin
            m_sel = -1;
            n_tmo = 1;
          end else begin
            m_age++;
          end
        end
        m_err = n_err;
        m_tmo = n_tmo;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [2:0] e_sel;
      e_sel = (m_sel >= 0) ? 3'(1 << m_sel) : 3'b000;
      chk("model_slave_sel", 32'(slave_sel), 32'(e_sel));
      chk("model_selr",      32'(selr),      32'(m_sel + 1));
      chk("model_busy",      32'(busy),      32'(m_sel >= 0));
      chk("model_dec_err",   32'(dec_err),   32'(m_err));
      chk("model_timeout",   32'(timeout),   32'(m_tmo));
      chk("model_req_ready", 32'(req_ready), 32'((m_sel < 0) && !m_err));
    end
  end

  // ---------------- drivers ----------------
  task automatic send_req(input logic [15:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; txn_done = 1'b0;

    chk("decode_0400", 32'(decode(16'h0400)), 32'(0));
    chk("decode_1abc", 32'(decode(16'h1ABC)), 32'(1));
    chk("decode_2fff", 32'(decode(16'h2FFF)), 32'(2));
    chk("decode_0800", 32'(decode(16'h0800)), 32'(-1));
    chk("decode_3000", 32'(decode(16'h3000)), 32'(-1));

    idle_cycles(3);
    chk("rst_sel",   32'(slave_sel), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_ready", 32'(req_ready), 32'(1));
    rst_n = 1'b1;
    idle_cycles(2);

    // 1: slave 0, done three cycles later
    send_req(16'h0400);
    chk("t1_sel",  32'(slave_sel), 32'(3'b001));
    chk("t1_selr", 32'(selr),      32'(1));
    chk("t1_busy", 32'(busy),      32'(1));
    idle_cycles(1);
    pulse_done();
    chk("t1_rel_sel",   32'(slave_sel), 32'(0));
    chk("t1_rel_ready", 32'(req_ready), 32'(1));
    idle_cycles(1);

    // 2: back-to-back slaves 1 and 2 with a single zero-select gap
    send_req(16'h1ABC);
    chk("t2a_sel",  32'(slave_sel), 32'(3'b010));
    chk("t2a_selr", 32'(selr),      32'(2));
    idle_cycles(1);
    pulse_done();
    chk("t2_gap_sel", 32'(slave_sel), 32'(0));
    req_valid = 1'b1;
    req_addr  = 16'h2FFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t2b_sel",  32'(slave_sel), 32'(3'b100));
    chk("t2b_selr", 32'(selr),      32'(3));
    pulse_done();
    idle_cycles(1);

    // 3: unmapped addresses
    send_req(16'h0800);
    chk("t3a_err",   32'(dec_err),   32'(1));
    chk("t3a_sel",   32'(slave_sel), 32'(0));
    chk("t3a_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("t3a_err_off", 32'(dec_err),   32'(0));
    chk("t3a_ready2",  32'(req_ready), 32'(1));
    send_req(16'h3000);
    chk("t3b_err", 32'(dec_err), 32'(1));
    idle_cycles(2);

    // 4: timeout exactly TMO cycles after busy rises
    send_req(16'h1000);
    chk("t4_busy", 32'(busy), 32'(1));
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      chk("t4_no_tmo", 32'(timeout), 32'(0));
    end
    @(negedge clk);
    chk("t4_tmo",     32'(timeout),   32'(1));
    chk("t4_tmo_sel", 32'(slave_sel), 32'(0));
    chk("t4_tmo_bsy", 32'(busy),      32'(0));
    @(negedge clk);
    chk("t4_tmo_off", 32'(timeout), 32'(0));
    idle_cycles(1);

    // 5: done on the final cycle beats timeout; requests during BUSY are ignored
    send_req(16'h1000);
    req_valid = 1'b1;
    req_addr  = 16'h2000;
    idle_cycles(TMO - 1);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done  = 1'b0;
    req_valid = 1'b0;
    chk("t5_no_tmo", 32'(timeout),   32'(0));
    chk("t5_sel",    32'(slave_sel), 32'(0));
    chk("t5_busy",   32'(busy),      32'(0));
    idle_cycles(2);

    // 6: asynchronous reset in the middle of a transaction
    send_req(16'h2100);
    chk("t6_sel", 32'(slave_sel), 32'(3'b100));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sel",   32'(slave_sel), 32'(0));
    chk("t6_rst_selr",  32'(selr),      32'(0));
    chk("t6_rst_busy",  32'(busy),      32'(0));
    chk("t6_rst_ready", 32'(req_ready), 32'(1));
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    send_req(16'h0000);
    chk("t6_post_sel",  32'(slave_sel), 32'(3'b001));
    chk("t6_post_selr", 32'(selr),      32'(1));
    pulse_done();
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
